// File: rtl/seq_tx_pkg.sv
// ---------------------------------------------------------------------------
// seq_tx_pkg
// Shared definitions for the serial pattern transmitter.
//   state_t            : FSM states IDLE, SEND, DONE
//   DEFAULT_WIDTH      : default pattern register width in bits
//   DEFAULT_BIT_TICKS  : default number of clock cycles each bit is held
// ---------------------------------------------------------------------------
package seq_tx_pkg;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_BIT_TICKS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bit_timer.sv
// ---------------------------------------------------------------------------
// bit_timer
// Counts clock cycles inside one bit period and flags the last one.
//   clk      in  1  clock, rising edge
//   reset_n  in  1  asynchronous active-low reset
//   enable   in  1  count while high; counter held at 0 while low
//   tick     out 1  high in the last cycle of a bit period (counter wraps)
// BIT_TICKS legal range is 1..255.
// ---------------------------------------------------------------------------
module bit_timer
    import seq_tx_pkg::*;
#(
    parameter int BIT_TICKS = DEFAULT_BIT_TICKS
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam logic [7:0] LAST_COUNT = 8'(BIT_TICKS - 1);

    logic [7:0] count;

    // With BIT_TICKS=1 the counter never leaves 0 and tick is simply enable,
    // so every enabled cycle ends a bit period.
    assign tick = enable && (count == LAST_COUNT);

    // Counter restarts from 0 whenever it is idle or has just wrapped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= 8'd0;
        end else if (!enable || tick) begin
            count <= 8'd0;
        end else begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/seq_transmitter.sv
// ---------------------------------------------------------------------------
// seq_transmitter
// Sends bits pattern[len] down to pattern[0] on a serial line, each bit held
// for BIT_TICKS cycles, followed by a one-cycle done pulse.
//   clk         in  1      clock, rising edge
//   reset_n     in  1      asynchronous active-low reset
//   start       in  1      frame request, sampled in IDLE only
//   pattern     in  WIDTH  bits to transmit, captured on acceptance
//   len         in  clog2  number of bits minus one, captured on acceptance
//   serial_out  out 1      registered serial line, IDLE_LEVEL when not sending
//   busy        out 1      registered, high for every cycle a bit is on the line
//   done        out 1      registered, one-cycle pulse after the last bit
// ---------------------------------------------------------------------------
module seq_transmitter
    import seq_tx_pkg::*;
#(
    parameter int   WIDTH      = DEFAULT_WIDTH,
    parameter int   BIT_TICKS  = DEFAULT_BIT_TICKS,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [WIDTH-1:0]         pattern,
    input  logic [$clog2(WIDTH)-1:0] len,
    output logic                     serial_out,
    output logic                     busy,
    output logic                     done
);

    localparam int LEN_W = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pat_q, pat_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   idx_dec;
    logic               serial_d, busy_d, done_d;
    logic               tick;

    bit_timer #(
        .BIT_TICKS (BIT_TICKS)
    ) u_bit_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (state_q == SEND),
        .tick    (tick)
    );

    assign idx_dec = idx_q - LEN_W'(1);

    // State, capture registers and the three outputs all live in flops so
    // no input reaches an output combinationally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pat_q      <= '0;
            idx_q      <= '0;
            serial_out <= IDLE_LEVEL;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            idx_q      <= idx_d;
            serial_out <= serial_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    // Next-state and next-output logic. The output values computed here are
    // what the line shows in the following cycle, which gives the first bit
    // its single cycle of latency after the accepting edge.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        idx_d    = idx_q;
        serial_d = IDLE_LEVEL;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SEND;
                    pat_d    = pattern;
                    idx_d    = len;
                    serial_d = pattern[len];
                    busy_d   = 1'b1;
                end
            end

            SEND: begin
                serial_d = serial_out;
                busy_d   = 1'b1;
                if (tick) begin
                    if (idx_q == '0) begin
                        state_d  = DONE;
                        serial_d = IDLE_LEVEL;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        idx_d    = idx_dec;
                        serial_d = pat_q[idx_dec];
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_transmitter.sv
// ---------------------------------------------------------------------------
// tb_seq_transmitter
// Self-checking bench for seq_transmitter. Two instances share clock and
// reset: dut8 (BIT_TICKS=8) and dut1 (BIT_TICKS=1). Expected per-cycle
// {serial_out, busy, done} samples are queued when a frame is requested and
// compared on each falling edge; with nothing queued the line must be idle.
// ---------------------------------------------------------------------------
module tb_seq_transmitter;

    typedef struct packed {
        logic serial;
        logic busy;
        logic done;
    } exp_t;

    typedef struct {
        logic [7:0] pattern;
        logic [2:0] len;
        logic [7:0] exp_bits;
    } vec_t;

    localparam logic [2:0] IDLE_OUT = 3'b000;

    logic       clk;
    logic       reset_n;
    logic       start8, start1;
    logic [7:0] pattern8, pattern1;
    logic [2:0] len8, len1;
    logic       serial8, busy8, done8;
    logic       serial1, busy1, done1;

    exp_t q8[$];
    exp_t q1[$];
    exp_t e8, e1;
    logic check_en;
    int   checks;
    int   errors;

    vec_t vec8[7];
    vec_t vec1[2];

    seq_transmitter #(
        .WIDTH      (8),
        .BIT_TICKS  (8),
        .IDLE_LEVEL (1'b0)
    ) dut8 (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start8),
        .pattern    (pattern8),
        .len        (len8),
        .serial_out (serial8),
        .busy       (busy8),
        .done       (done8)
    );

    seq_transmitter #(
        .WIDTH      (8),
        .BIT_TICKS  (1),
        .IDLE_LEVEL (1'b0)
    ) dut1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start1),
        .pattern    (pattern1),
        .len        (len1),
        .serial_out (serial1),
        .busy       (busy1),
        .done       (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string name, input logic [2:0] got, input logic [2:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s t=%0t serial/busy/done got %b expected %b", name, $time, got, expv);
        end
    endtask

    function automatic int qsize(input int sel);
        return (sel == 8) ? q8.size() : q1.size();
    endfunction

    task automatic pushEntry(input int sel, input logic s, input logic b, input logic d);
        exp_t e;
        e.serial = s;
        e.busy   = b;
        e.done   = d;
        if (sel == 8) q8.push_back(e);
        else          q1.push_back(e);
    endtask

    // Expected line for one frame: each bit for bt cycles, then the done cycle.
    task automatic pushFrame(input int sel, input logic [7:0] bits, input int len_i);
        int bt;
        bt = (sel == 8) ? 8 : 1;
        for (int i = 0; i < (len_i + 1) * bt; i++) begin
            pushEntry(sel, bits[len_i - i / bt], 1'b1, 1'b0);
        end
        pushEntry(sel, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic driveInputs(input int sel, input logic st, input logic [7:0] pat, input logic [2:0] ln);
        if (sel == 8) begin
            start8 = st; pattern8 = pat; len8 = ln;
        end else begin
            start1 = st; pattern1 = pat; len1 = ln;
        end
    endtask

    task automatic waitDrain(input int sel, input int budget);
        int n;
        n = 0;
        while (qsize(sel) > 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (qsize(sel) > 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout dut%0d remaining %0d expected 0", sel, qsize(sel));
            if (sel == 8) q8.delete();
            else          q1.delete();
        end
    endtask

    // One-cycle start pulse for a single frame, expectations queued at drive time.
    task automatic applyStimulus(input int sel, input logic [7:0] pat, input logic [2:0] ln, input logic [7:0] bits);
        @(posedge clk);
        #1;
        driveInputs(sel, 1'b1, pat, ln);
        pushEntry(sel, 1'b0, 1'b0, 1'b0);
        pushFrame(sel, bits, int'(ln));
        @(posedge clk);
        #1;
        driveInputs(sel, 1'b0, pat, ln);
        waitDrain(sel, 200);
        repeat (3) @(posedge clk);
    endtask

    // Scoreboard: pop one expected sample per cycle, or demand an idle line.
    always @(negedge clk) begin
        if (check_en) begin
            if (q8.size() > 0) begin
                e8 = q8.pop_front();
                checkOutput("dut8_frame", {serial8, busy8, done8}, e8);
            end else begin
                checkOutput("dut8_idle", {serial8, busy8, done8}, IDLE_OUT);
            end
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                checkOutput("dut1_frame", {serial1, busy1, done1}, e1);
            end else begin
                checkOutput("dut1_idle", {serial1, busy1, done1}, IDLE_OUT);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec8[0] = '{8'h0D, 3'd3, 8'b0000_1101};
        vec8[1] = '{8'h01, 3'd0, 8'b0000_0001};
        vec8[2] = '{8'hA5, 3'd7, 8'b1010_0101};
        vec8[3] = '{8'h80, 3'd7, 8'b1000_0000};
        vec8[4] = '{8'h3C, 3'd5, 8'b0011_1100};
        vec8[5] = '{8'hF0, 3'd2, 8'b0000_0000};
        vec8[6] = '{8'h6E, 3'd4, 8'b0000_1110};
        vec1[0] = '{8'hB4, 3'd7, 8'b1011_0100};
        vec1[1] = '{8'h5A, 3'd1, 8'b0000_0010};

        checks   = 0;
        errors   = 0;
        check_en = 1'b0;
        reset_n  = 1'b0;
        driveInputs(8, 1'b0, 8'h00, 3'd0);
        driveInputs(1, 1'b0, 8'h00, 3'd0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_dut8", {serial8, busy8, done8}, IDLE_OUT);
        checkOutput("reset_dut1", {serial1, busy1, done1}, IDLE_OUT);
        reset_n  = 1'b1;
        check_en = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] table vectors, BIT_TICKS=8");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(8, vec8[i].pattern, vec8[i].len, vec8[i].exp_bits);
        end

        $display("[TB] table vectors, BIT_TICKS=1");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, vec1[i].pattern, vec1[i].len, vec1[i].exp_bits);
        end

        // Second request in cycle 10 with new pattern/len must be ignored.
        $display("[TB] start during SEND");
        @(posedge clk);
        #1;
        driveInputs(8, 1'b1, 8'h0D, 3'd3);
        pushEntry(8, 1'b0, 1'b0, 1'b0);
        pushFrame(8, 8'b0000_1101, 3);
        @(posedge clk);
        #1;
        driveInputs(8, 1'b0, 8'h0D, 3'd3);
        repeat (9) @(posedge clk);
        #1;
        driveInputs(8, 1'b1, 8'hFF, 3'd7);
        @(posedge clk);
        #1;
        driveInputs(8, 1'b0, 8'hFF, 3'd7);
        waitDrain(8, 200);
        repeat (4) @(posedge clk);

        // Reset asserted in cycle 12 of a frame aborts it without done.
        $display("[TB] reset mid-frame");
        @(posedge clk);
        #1;
        driveInputs(8, 1'b1, 8'h0D, 3'd3);
        pushEntry(8, 1'b0, 1'b0, 1'b0);
        pushFrame(8, 8'b0000_1101, 3);
        @(posedge clk);
        #1;
        driveInputs(8, 1'b0, 8'h0D, 3'd3);
        repeat (11) @(posedge clk);
        #1;
        check_en = 1'b0;
        q8.delete();
        checkOutput("pre_reset_dut8", {serial8, busy8, done8}, 3'b110);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_dut8", {serial8, busy8, done8}, IDLE_OUT);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_hold_dut8", {serial8, busy8, done8}, IDLE_OUT);
        reset_n  = 1'b1;
        check_en = 1'b1;
        repeat (3) @(posedge clk);
        applyStimulus(8, 8'h0D, 3'd3, 8'b0000_1101);

        // Held start: three back-to-back frames separated by DONE + IDLE.
        $display("[TB] start held high");
        @(posedge clk);
        #1;
        driveInputs(8, 1'b1, 8'hA5, 3'd7);
        pushEntry(8, 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 3; f++) begin
            pushFrame(8, 8'hA5, 7);
            if (f < 2) pushEntry(8, 1'b0, 1'b0, 1'b0);
        end
        waitDrain(8, 400);
        driveInputs(8, 1'b0, 8'hA5, 3'd7);
        repeat (4) @(posedge clk);

        #1;
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_transmitter.md
SEQ_TRANSMITTER -- requirements
Module: seq_transmitter

Interface
REQ-001 Parameter WIDTH, default 8, pattern register width in bits.
REQ-002 Parameter BIT_TICKS, default 8, clock cycles each bit is held on the line; legal range 1 to 255.
REQ-003 Parameter IDLE_LEVEL, default 1'b0, line level driven whenever no frame is being sent.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  frame request, level-sampled each cycle.
REQ-007 pattern  input  WIDTH  bits to transmit.
REQ-008 len  input  $clog2(WIDTH)  number of bits to send minus one (0 sends 1 bit; WIDTH-1 sends WIDTH bits).
REQ-009 serial_out  output  1  registered serial line.
REQ-010 busy  output  1  high while a frame is on the line.
REQ-011 done  output  1  one-cycle pulse at frame end.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SEND and DONE.
REQ-013 In IDLE, start=1 at a rising edge SHALL capture pattern and len into internal registers and move to SEND.
REQ-014 Bits SHALL go out MSB-first from the captured pattern, in the order pattern[len], pattern[len-1], ..., pattern[0].
REQ-015 serial_out SHALL show pattern[len] in the first cycle after the accepting edge: one cycle of latency.
REQ-016 Each bit SHALL stay on serial_out for exactly BIT_TICKS consecutive cycles.
REQ-017 The tick counter SHALL run from 0 to BIT_TICKS-1 and then wrap to 0; each wrap decrements the bit index.
REQ-018 At the wrap of the bit-0 period, the FSM SHALL move SEND->DONE.
REQ-019 In DONE (one cycle): done=1, busy=0, serial_out=IDLE_LEVEL. The FSM then moves DONE->IDLE unconditionally.
REQ-020 busy SHALL be 1 in every SEND cycle and 0 in every other cycle.
REQ-021 start SHALL be ignored in SEND and DONE; no request is queued.
REQ-022 Changes on pattern or len during SEND SHALL NOT affect the frame in flight.
REQ-023 If start is held high continuously, frames SHALL repeat with exactly two IDLE_LEVEL cycles (DONE, then IDLE) between the last bit of one frame and the first bit of the next.
REQ-024 A frame SHALL last (len+1)*BIT_TICKS cycles, with done asserted in the cycle that follows.
REQ-025 With BIT_TICKS=1 each bit SHALL last one cycle, and no counter overflow or skipped bit is permitted.

Reset
REQ-026 Asserting reset_n=0 SHALL immediately force state=IDLE, serial_out=IDLE_LEVEL, busy=0, done=0, and clear the counters and capture registers.
REQ-027 Reset during SEND SHALL abort the frame with no done pulse; the first edge after release SHALL be treated as IDLE.
REQ-028 Reset release is synchronised externally; the block SHALL NOT add a synchroniser.

Structure
REQ-029 Package seq_tx_pkg SHALL hold the state enum (IDLE, SEND, DONE) and the default constants for WIDTH and BIT_TICKS.
REQ-030 The tick counter SHALL be a sub-module, bit_timer (inputs clk, reset_n, enable; output tick pulse on wrap). The FSM, bit index, shift register and output register SHALL stay in seq_transmitter.
REQ-031 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.

Verification (WIDTH=8, BIT_TICKS=8 unless noted)
REQ-032 pattern=8'h0D, len=3, one-cycle start -> serial_out 1,1,0,1 for 8 cycles each, in cycles 1-32 after the accepting edge; done=1 in cycle 33; busy=1 in cycles 1-32 only.
REQ-033 pattern=8'h01, len=0 -> serial_out=1 for 8 cycles; done in cycle 9.
REQ-034 start pulsed again in cycle 10 of a len=3 frame, with pattern changed to 8'hFF -> the frame is unchanged (1,1,0,1) and exactly one done pulse is produced.
REQ-035 reset_n driven low in cycle 12 of a frame -> serial_out=0, busy=0 asynchronously, no done pulse; after release, a new start sends a full frame.
REQ-036 start held high, pattern=8'hA5, len=7 -> frames repeat with a 2-cycle low gap between them; one done per frame.
REQ-037 BIT_TICKS=1, pattern=8'hB4, len=7 -> serial_out 1,0,1,1,0,1,0,0 in cycles 1-8; done in cycle 9.
